// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel drivers: scan-state encoding, the fixed
// number of cycles spent between bit-planes, and a constant-width helper.
package hub75_pkg;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b000_0001,
        S_SHIFT   = 7'b000_0010,
        S_WAIT    = 7'b000_0100,
        S_BLANK   = 7'b000_1000,
        S_LATCH   = 7'b001_0000,
        S_UNLATCH = 7'b010_0000,
        S_UNBLANK = 7'b100_0000
    } scan_state_e;

    // BLANK, LATCH, UNLATCH and UNBLANK sit between every pair of planes.
    localparam int LATCH_OVERHEAD = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcm_display_timer.sv
// Down-counter that times how long one BCM plane stays lit. expire_pulse is high
// in the cycle whose closing edge takes the count from 1 to 0.
module bcm_display_timer #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         expire_pulse
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    assign busy         = (count_q != '0);
    assign expire_pulse = !load && (count_q == W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 scan scheduler: walks row x bit-plane, pulls one column pair per handshake,
// and overlaps the shift of the next plane with the display of the current one.
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int ADDR_BITS   = 5,
    parameter int PLANES      = 8,
    parameter int BRIGHT_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [BRIGHT_BITS-1:0]     brightness,
    output logic                       px_req,
    output logic [clog2(WIDTH)-1:0]    px_x,
    output logic [ADDR_BITS-1:0]       px_row,
    output logic [clog2(PLANES)-1:0]   px_plane,
    input  logic                       px_ack,
    input  logic [2:0]                 px_rgb0,
    input  logic [2:0]                 px_rgb1,
    output logic [2:0]                 led_rgb0,
    output logic [2:0]                 led_rgb1,
    output logic [ADDR_BITS-1:0]       led_addr,
    output logic                       led_blank,
    output logic                       led_latch,
    output logic                       sclk_ena,
    output logic                       frame_start
);

    localparam int XW = clog2(WIDTH);
    localparam int PW = clog2(PLANES);
    localparam int TW = BRIGHT_BITS + PLANES - 1;

    scan_state_e            state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [ADDR_BITS-1:0]   row_q, row_d;
    logic [PW-1:0]          plane_q, plane_d;
    logic [BRIGHT_BITS-1:0] bright_q, bright_d;
    logic [2:0]             rgb0_q, rgb0_d;
    logic [2:0]             rgb1_q, rgb1_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   blank_q, blank_d;
    logic                   latch_q, latch_d;
    logic                   sclk_q, sclk_d;
    logic                   fs_q, fs_d;

    logic                   tmr_load;
    logic [TW-1:0]          tmr_load_val;
    logic                   tmr_busy;
    logic                   tmr_expire;

    // The plane being latched is the one displayed, so its weight sets the on-time.
    assign tmr_load_val = TW'(bright_q) << plane_q;

    bcm_display_timer #(
        .W (TW)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (tmr_load),
        .load_val     (tmr_load_val),
        .busy         (tmr_busy),
        .expire_pulse (tmr_expire)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d  = state_q;
        x_d      = x_q;
        row_d    = row_q;
        plane_d  = plane_q;
        bright_d = bright_q;
        rgb0_d   = rgb0_q;
        rgb1_d   = rgb1_q;
        addr_d   = addr_q;
        blank_d  = blank_q;
        latch_d  = latch_q;
        sclk_d   = 1'b0;
        fs_d     = 1'b0;
        tmr_load = 1'b0;

        if (tmr_expire) begin
            blank_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!tmr_busy) begin
                    blank_d = 1'b1;
                end
                if (enable) begin
                    fs_d     = 1'b1;
                    bright_d = brightness;
                    row_d    = '0;
                    plane_d  = '0;
                    x_d      = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Shift clock is only enabled behind a real data beat.
                if (px_ack) begin
                    rgb0_d = px_rgb0;
                    rgb1_d = px_rgb1;
                    sclk_d = 1'b1;
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d     = '0;
                        state_d = S_WAIT;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!tmr_busy) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                blank_d = 1'b1;
                addr_d  = row_q;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                latch_d = 1'b1;
                state_d = S_UNLATCH;
            end
            S_UNLATCH: begin
                latch_d = 1'b0;
                state_d = S_UNBLANK;
            end
            S_UNBLANK: begin
                if (bright_q != '0) begin
                    blank_d  = 1'b0;
                    tmr_load = 1'b1;
                end
                if (plane_q == PW'(PLANES - 1)) begin
                    plane_d = '0;
                    if (row_q == '1) begin
                        row_d    = '0;
                        fs_d     = 1'b1;
                        bright_d = brightness;
                    end else begin
                        row_d = row_q + ADDR_BITS'(1);
                    end
                end else begin
                    plane_d = plane_q + PW'(1);
                end
                state_d = enable ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            row_q    <= '0;
            plane_q  <= '0;
            bright_q <= '0;
            rgb0_q   <= '0;
            rgb1_q   <= '0;
            addr_q   <= '0;
            blank_q  <= 1'b1;
            latch_q  <= 1'b0;
            sclk_q   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values from
            // before this edge, independent of statement order.
            state_q  <= state_d;
            x_q      <= x_d;
            row_q    <= row_d;
            plane_q  <= plane_d;
            bright_q <= bright_d;
            rgb0_q   <= rgb0_d;
            rgb1_q   <= rgb1_d;
            addr_q   <= addr_d;
            blank_q  <= blank_d;
            latch_q  <= latch_d;
            sclk_q   <= sclk_d;
            fs_q     <= fs_d;
        end
    end

    assign px_req      = (state_q == S_SHIFT);
    assign px_x        = x_q;
    assign px_row      = row_q;
    assign px_plane    = plane_q;
    assign led_rgb0    = rgb0_q;
    assign led_rgb1    = rgb1_q;
    assign led_addr    = addr_q;
    assign led_blank   = blank_q;
    assign led_latch   = latch_q;
    assign sclk_ena    = sclk_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Directed bench for hub75_bcm_scheduler: a pixel source with stall control, a
// pin monitor that measures shift/latch/on-time behaviour, and scenario checks.
`timescale 1ns/1ps
module tb_hub75_bcm_scheduler;
    import hub75_pkg::*;

    localparam int WIDTH       = 64;
    localparam int ADDR_BITS   = 5;
    localparam int PLANES      = 8;
    localparam int BRIGHT_BITS = 8;
    localparam int ROWS        = 1 << ADDR_BITS;
    // Shift-limited plane: 64 shift + 1 WAIT + 4 overhead = 69 clocks.
    localparam int FRAME_DARK  = ROWS * PLANES * (WIDTH + 1 + LATCH_OVERHEAD);  // 17664
    // brightness=1: plane-0 shift of rows 1..31 waits on the 128-clock plane-7
    // display (133 instead of 69), plus the 3-cycle stall in the first plane.
    localparam int FRAME_B1    = FRAME_DARK + (ROWS - 1) * 64 + 3;               // 19651

    logic                   clk;
    logic                   reset_n;
    logic                   enable;
    logic [BRIGHT_BITS-1:0] brightness;
    logic                   px_req;
    logic [5:0]             px_x;
    logic [ADDR_BITS-1:0]   px_row;
    logic [2:0]             px_plane;
    logic                   px_ack;
    logic [2:0]             px_rgb0, px_rgb1;
    logic [2:0]             led_rgb0, led_rgb1;
    logic [ADDR_BITS-1:0]   led_addr;
    logic                   led_blank, led_latch, sclk_ena, frame_start;

    logic hold, spur;
    logic [2:0] exp_rgb0, exp_rgb1;

    int tests_run    = 0;
    int tests_failed = 0;

    hub75_bcm_scheduler #(
        .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .PLANES(PLANES), .BRIGHT_BITS(BRIGHT_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .brightness(brightness),
        .px_req(px_req), .px_x(px_x), .px_row(px_row), .px_plane(px_plane),
        .px_ack(px_ack), .px_rgb0(px_rgb0), .px_rgb1(px_rgb1),
        .led_rgb0(led_rgb0), .led_rgb1(led_rgb1), .led_addr(led_addr),
        .led_blank(led_blank), .led_latch(led_latch), .sclk_ena(sclk_ena),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] src_pix(input logic [5:0] x, input logic [4:0] r,
                                           input logic [2:0] p);
        return {x[5:3] ^ r[4:2] ^ 3'b101, x[2:0] ^ r[2:0] ^ p};
    endfunction

    assign {px_rgb1, px_rgb0} = src_pix(px_x, px_row, px_plane);
    assign px_ack = (px_req && !hold) || spur;

    always @(posedge clk) begin
        if (px_ack && px_req) {exp_rgb1, exp_rgb0} <= src_pix(px_x, px_row, px_plane);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pin monitor state
    int cyc, sclk_since, plane_sclk, sclk_min, sclk_max;
    int latch_idx, last_plane, last_addr, latch_gap, rise_cyc;
    int low_run, last_on, on_p7, sclk_at_rise;
    int on_err, addr_err, blank_err, rgb_err, latch_wide;
    int fs_cnt, fs_last, fs_period, fs_wide;
    int bright_exp;
    bit low_seen, latch_prev, fs_prev;

    task automatic clear_mon();
        cyc = 0; sclk_since = 0; plane_sclk = 0; sclk_min = 1 << 30; sclk_max = 0;
        latch_idx = 0; last_plane = 0; last_addr = 0; latch_gap = 0; rise_cyc = 0;
        low_run = 0; last_on = 0; on_p7 = 0; sclk_at_rise = 0;
        on_err = 0; addr_err = 0; blank_err = 0; rgb_err = 0; latch_wide = 0;
        fs_cnt = 0; fs_last = 0; fs_period = 0; fs_wide = 0;
        low_seen = 0; latch_prev = 0; fs_prev = 0;
    endtask

    always @(posedge clk) begin
        #2;
        if (!reset_n) begin
            low_run = 0; latch_prev = 0; fs_prev = 0;
        end else begin
            cyc++;
            if (sclk_ena) begin
                sclk_since++;
                if (led_rgb0 !== exp_rgb0 || led_rgb1 !== exp_rgb1) rgb_err++;
            end
            if (!led_blank) begin
                low_run++;
                low_seen = 1;
            end else if (low_run > 0) begin
                last_on      = low_run;
                sclk_at_rise = sclk_since;
                rise_cyc     = cyc;
                if (last_plane == PLANES - 1) on_p7 = low_run;
                if (low_run != (bright_exp << last_plane)) on_err++;
                low_run = 0;
            end
            if (led_latch) begin
                if (latch_prev) latch_wide++;
                if (int'(led_addr) != (latch_idx / PLANES) % ROWS) addr_err++;
                if (!led_blank) blank_err++;
                plane_sclk = sclk_since;
                if (plane_sclk < sclk_min) sclk_min = plane_sclk;
                if (plane_sclk > sclk_max) sclk_max = plane_sclk;
                sclk_since = 0;
                latch_gap  = cyc - rise_cyc;
                last_plane = latch_idx % PLANES;
                last_addr  = int'(led_addr);
                latch_idx++;
            end
            latch_prev = led_latch;
            if (frame_start) begin
                if (fs_prev) fs_wide++;
                fs_cnt++;
                fs_period = cyc - fs_last;
                fs_last   = cyc;
            end
            fs_prev = frame_start;
        end
    end

    task automatic wait_latch(input int target, input int budget, input string tag);
        int n = 0;
        while (latch_idx < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, latch_idx, target);
    endtask

    task automatic wait_fs(input int target, input int budget, input string tag);
        int n = 0;
        while (fs_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, fs_cnt, target);
    endtask

    task automatic restart(input int bright);
        @(negedge clk);
        reset_n = 1'b0;
        brightness = BRIGHT_BITS'(bright);
        bright_exp = bright;
        clear_mon();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        int n;
        logic [4:0] s_row;
        logic [2:0] s_plane;
        reset_n = 1'b0; enable = 1'b0; brightness = '0; hold = 1'b0; spur = 1'b0;
        bright_exp = 0;
        clear_mon();

        // Reset state
        @(negedge clk);
        check("rst_blank", led_blank, 1);
        check("rst_outputs", {px_req, led_latch, sclk_ena, frame_start, led_addr,
                              led_rgb0, led_rgb1, px_x, px_row, px_plane}, 0);

        // Spurious ack in IDLE is ignored
        reset_n = 1'b1; spur = 1'b1; brightness = 8'd1; bright_exp = 1;
        repeat (3) @(negedge clk);
        check("spur_sclk", {sclk_ena, px_req, led_rgb0, led_rgb1}, 0);
        spur = 1'b0;

        // Scenario 1: brightness 1, stall at x=10, brightness change mid-frame
        enable = 1'b1;
        @(negedge clk);
        check("start_fs", {frame_start, px_req}, 2'b11);
        check("start_pos", {px_x, px_row, px_plane}, 0);
        n = 0;
        while (!(px_req && px_x == 6'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_x10", px_x, 10);
        hold = 1'b1;
        s_row = px_row; s_plane = px_plane;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req", {px_req, px_x}, {1'b1, 6'd10});
            check("stall_rowplane", {px_row, px_plane}, {s_row, s_plane});
            check("stall_sclk", sclk_ena, 0);
        end
        hold = 1'b0;
        brightness = 8'd3;
        wait_latch(1, 200, "p0_latch");
        check("p0_cols", plane_sclk, 64);
        wait_fs(2, 25000, "frame1_end");
        check("frame1_period", fs_period, FRAME_B1);
        check("frame1_latches", latch_idx, ROWS * PLANES);
        check("cols_min", sclk_min, 64);
        check("cols_max", sclk_max, 64);
        check("p7_on_time", on_p7, 128);
        check("on_time_err", on_err, 0);
        check("addr_err", addr_err, 0);
        check("latch_blank_err", blank_err, 0);
        check("latch_width_err", latch_wide, 0);
        check("fs_width_err", fs_wide, 0);
        check("rgb_err", rgb_err, 0);

        // Scenario 2: brightness 40, plane 7 display dominates the next shift
        restart(40);
        wait_latch(8, 8000, "b40_p7_latch");
        n = 0;
        while (on_p7 == 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("b40_p7_on", on_p7, 5120);
        check("b40_shift_done", sclk_at_rise, 64);
        wait_latch(9, 100, "b40_next_latch");
        check("b40_latch_gap", latch_gap, 3);
        check("b40_next_addr", last_addr, 1);
        check("b40_on_err", on_err, 0);

        // Scenario 3: asynchronous reset while shifting with the panel lit
        n = 0;
        while (!(px_req && !led_blank) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lit_shift", {px_req, led_blank}, 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_blank", led_blank, 1);
        check("arst_outs", {led_latch, sclk_ena, led_addr, px_req, frame_start}, 0);
        brightness = 8'd0;
        bright_exp = 0;
        clear_mon();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_restart_fs", {frame_start, px_req}, 2'b11);
        check("arst_restart_pos", {px_x, px_row, px_plane}, 0);

        // Scenario 4: brightness 0 keeps the panel dark but sequencing runs
        wait_fs(2, 20000, "dark_frame_end");
        check("dark_period", fs_period, FRAME_DARK);
        check("dark_latches", latch_idx, ROWS * PLANES);
        check("dark_never_lit", low_seen, 0);
        check("dark_addr_err", addr_err, 0);
        check("dark_cols", {sclk_min[7:0], sclk_max[7:0]}, {8'd64, 8'd64});

        // Scenario 5: enable dropped mid-shift at row 5 plane 2
        restart(1);
        wait_latch(5 * PLANES + 2, 5000, "row5_p1_latch");
        n = 0;
        while (!(px_req && px_row == 5'd5 && px_plane == 3'd2 && px_x == 6'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("row5_p2_shift", {px_row, px_plane, px_x}, {5'd5, 3'd2, 6'd5});
        enable = 1'b0;
        wait_latch(5 * PLANES + 3, 200, "row5_p2_latch");
        check("drop_addr", last_addr, 5);
        check("drop_plane", last_plane, 2);
        repeat (60) @(negedge clk);
        check("drop_on_time", last_on, 4);
        check("drop_idle", {led_blank, px_req, sclk_ena, led_latch}, 4'b1000);
        check("drop_no_more", {latch_idx, sclk_since}, {32'(5 * PLANES + 3), 32'd0});
        check("drop_on_err", on_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_scheduler.md
Name: hub75_bcm_scheduler

Overview:
- Scan scheduler for a HUB75 LED panel using binary-coded modulation (BCM).
- Walks row address × bit-plane, fetches one bit-plane column pair per handshake from an upstream pixel source, and drives the panel shift/blank/latch/address pins.
- Runs a per-plane display timer that overlaps the next plane's shift.
- Replaces the inline compare-based scan FSM; sclk_ena feeds the existing DDR sclk output cell.

Parameters:
- WIDTH, 64: columns shifted per row; power of two, ≥4.
- ADDR_BITS, 5: row-address width; rows = 2**ADDR_BITS.
- PLANES, 8: BCM bit-planes per row, MSB plane = PLANES-1.
- BRIGHT_BITS, 8: width of the brightness input.

Ports:
- clk  in  1  system clock (30 MHz PLL clock).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run scan; low = finish current latch then idle blanked.
- brightness  in  BRIGHT_BITS  on-time unit in clocks; sampled at frame start.
- px_req  out  1  pixel request valid.
- px_x  out  log2(WIDTH)  requested column.
- px_row  out  ADDR_BITS  requested row (top half; bottom half implied).
- px_plane  out  log2(PLANES)  requested bit-plane.
- px_ack  in  1  source has data this cycle.
- px_rgb0  in  3  top-half {r,g,b} plane bits, valid with px_ack.
- px_rgb1  in  3  bottom-half {r,g,b} plane bits, valid with px_ack.
- led_rgb0  out  3  panel top RGB data.
- led_rgb1  out  3  panel bottom RGB data.
- led_addr  out  ADDR_BITS  panel row address.
- led_blank  out  1  panel OE (1 = dark).
- led_latch  out  1  panel latch.
- sclk_ena  out  1  enable to DDR shift-clock cell.
- frame_start  out  1  one-cycle pulse at start of each frame.

Behaviour:
- Reset (async, reset_n=0): all outputs 0 except led_blank=1; FSM=IDLE; row=0, plane=0, x=0; display timer=0; brightness register=0.
- FSM states: IDLE, SHIFT, WAIT, BLANK, LATCH, UNLATCH, UNBLANK.
- IDLE:
  - led_blank=1.
  - When enable=1: pulse frame_start, sample brightness, row=0, plane=0, go SHIFT.
- SHIFT:
  - px_req=1 with px_x=x, px_row=row, px_plane=plane; request held stable until px_ack.
  - On px_ack: led_rgb0/1 <= px_rgb0/1, sclk_ena<=1 the same edge, x<=x+1.
  - Cycle without ack: sclk_ena<=0, so a clock edge is emitted only for valid data.
  - After the ack with x=WIDTH-1: sclk_ena<=0, x<=0, go WAIT.
- WAIT: hold until display timer==0, then go BLANK.
- Display timer:
  - Loaded in UNBLANK with brightness << plane; width BRIGHT_BITS+PLANES-1.
  - Decrements every cycle while nonzero, in any state.
  - On the 1→0 transition, led_blank<=1. On-time is therefore exactly brightness·2^plane clocks.
- BLANK: led_blank<=1, led_addr<=row, go LATCH.
- LATCH: led_latch<=1, go UNLATCH.
- UNLATCH: led_latch<=0, go UNBLANK.
- UNBLANK:
  - If brightness register ≠0: led_blank<=0 and load the timer. If 0: led_blank stays 1 and the timer stays 0.
  - Advance position: plane+1. On plane wrap: plane=0, row+1.
  - On row wrap (last row, last plane): row=0, pulse frame_start, resample brightness.
  - Go SHIFT if enable=1, else IDLE.
- Pipelining: the shift of plane p+1 overlaps the display of plane p.
- Lit period: minimum per plane = max(shift time, on-time), with 4 overhead cycles (BLANK, LATCH, UNLATCH, UNBLANK) between planes.
- enable falling mid-row: the current plane completes shift and latch; the display timer expires normally; then IDLE with blank=1.
- px_ack while px_req=0: ignored.
- brightness changes mid-frame: take effect only at the next frame_start.
- Reset mid-shift: immediate; the panel goes dark; the partially shifted row is discarded.

Decomposition:
- Shared package hub75_pkg holds:
  - FSM state encoding, one-hot, S_IDLE..S_UNBLANK;
  - LATCH_OVERHEAD=4;
  - function clog2.
- One sub-module: bcm_display_timer. It does load/decrement/expire, outputs expire_pulse, and is reusable by later panel drivers.

Test Plan:
- Source always acks, WIDTH=64, brightness=1, enable=1 → exactly 64 sclk_ena cycles per plane; latch high 1 cycle; plane-7 on-time = 128 clocks blank=0; frame_start every 32×8 planes.
- px_ack withheld 3 cycles at x=10 → px_x/px_row/px_plane stable; sclk_ena=0 during stall; column count still 64.
- brightness=40, plane 7 → blank low exactly 5120 clocks; next BLANK not before timer expiry, with shift already complete (WAIT observed).
- brightness=0 → led_blank never deasserts; latch/address sequencing still runs; frame_start period unchanged.
- enable dropped mid-shift at row 5 plane 2 → plane 2 latched with led_addr=5, timer expires, IDLE, blank=1, px_req=0.
- reset_n asserted mid-SHIFT, asynchronously between edges → outputs immediately blank=1, latch=0, sclk_ena=0, addr=0; restart begins at row 0 plane 0 with frame_start.
